f_fetch_ctrl: RTL and testbench

Fetch-stage controller for the pipelined MIPS core. It owns the F-stage program counter `F_PC` and runs the request/acknowledge exchange with instruction memory. It loads the F/D pipeline register (`D_PC`, `D_instr`, `D_valid`). Each time an instruction is accepted into D, it commits the next-PC value supplied by the nPC logic. It also holds instructions across hazard stalls and inserts bubbles while memory is slow.

---
 rtl/f_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_f_fetch_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_ctrl.sv
// rtl/f_fetch_ctrl.sv - MIPS fetch-stage controller: F_PC, imem handshake, F/D register
module f_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic        D_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] hold_instr;
  logic        avail;
  logic [31:0] avail_data;
  logic        advance;
  logic        bubble;
  logic        capture;

  // The request address is the fetch PC itself; no path from imem_ack.
  assign imem_addr = F_PC;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, request output and the advance/bubble/capture decisions.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    avail      = 1'b0;
    avail_data = hold_instr;
    bubble     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          avail      = 1'b1;
          avail_data = imem_rdata;
          if (stall) begin
            capture    = 1'b1;
            state_next = HOLD;
          end
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        avail = 1'b1;
        if (!stall) begin
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    advance = avail && !stall;
  end

  // Fetch PC and F/D pipeline register: load on advance, bubble on a missed ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F_PC    <= RESET_PC;
      D_PC    <= 32'h0000_0000;
      D_instr <= NOP;
      D_valid <= 1'b0;
    end else if (advance) begin
      F_PC    <= npc;
      D_PC    <= F_PC;
      D_instr <= avail_data;
      D_valid <= 1'b1;
    end else if (bubble) begin
      D_PC    <= F_PC;
      D_instr <= NOP;
      D_valid <= 1'b0;
    end
  end

  // Buffer for a word acknowledged while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_instr <= 32'h0000_0000;
    end else if (capture) begin
      hold_instr <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// tb/tb_f_fetch_ctrl.sv - self-checking bench for f_fetch_ctrl
module tb_f_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] npc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic        D_valid;

  f_fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .npc        (npc),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .F_PC       (F_PC),
    .D_PC       (D_PC),
    .D_instr    (D_instr),
    .D_valid    (D_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: fetch PC, D contents, and a queue of words fetched but not yet in D.
  logic [31:0] m_fpc, m_dpc, m_dinstr;
  logic        m_dvalid;
  logic        m_started;
  logic [31:0] m_q[$];

  // Memory and stimulus knobs.
  int          wait_k = 0;
  int          wcnt = 0;
  logic        stray = 1'b0;
  logic        rnd = 1'b0;
  logic [31:0] branch_at = 32'h0000_0001;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] special_addr = 32'h0000_0001;
  logic [31:0] special_data = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fpc     = 32'h0000_3000;
    m_dpc     = 32'h0;
    m_dinstr  = 32'h0;
    m_dvalid  = 1'b0;
    m_started = 1'b0;
    m_q.delete();
    wcnt      = 0;
  endtask

  // One clock cycle: drive memory/npc, check outputs against the model, step the model.
  task automatic tick();
    logic        exp_req;
    logic        have;
    logic [31:0] w;
    exp_req = m_started && (m_q.size() == 0);
    npc = (m_fpc == branch_at) ? branch_target : m_fpc + 32'd4;
    if (rnd && $urandom_range(0, 3) == 0) npc = $urandom & 32'hFFFF_FFFC;
    if (imem_req) imem_ack = (wcnt >= wait_k);
    else imem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
    if (imem_ack) imem_rdata = (m_fpc == special_addr) ? special_data : (m_fpc ^ 32'hFFFF_FFFF);
    else imem_rdata = $urandom;
    #2;
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    chk("imem_addr", imem_addr, m_fpc);
    chk("F_PC", F_PC, m_fpc);
    chk("D_PC", D_PC, m_dpc);
    chk("D_instr", D_instr, m_dinstr);
    chk("D_valid", {31'b0, D_valid}, {31'b0, m_dvalid});
    if (imem_req) begin
      if (imem_ack) begin
        wcnt = 0;
        if (rnd) wait_k = $urandom_range(0, 2);
      end else begin
        wcnt++;
      end
    end
    @(posedge clk);
    #1;
    if (!m_started) begin
      m_started = 1'b1;
    end else begin
      have = 1'b0;
      w = 32'h0;
      if (m_q.size() != 0) begin
        have = 1'b1;
        w = m_q[0];
      end else if (exp_req && imem_ack) begin
        have = 1'b1;
        w = imem_rdata;
      end
      if (have && !stall) begin
        m_dinstr = w;
        m_dpc    = m_fpc;
        m_dvalid = 1'b1;
        m_fpc    = npc;
        m_q.delete();
      end else if (have) begin
        if (m_q.size() == 0) m_q.push_back(w);
      end else if (exp_req && !stall) begin
        m_dinstr = 32'h0;
        m_dpc    = m_fpc;
        m_dvalid = 1'b0;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
    chk({tag, "_fpc"}, F_PC, 32'h0000_3000);
    chk({tag, "_addr"}, imem_addr, 32'h0000_3000);
    chk({tag, "_dpc"}, D_PC, 32'h0);
    chk({tag, "_dinstr"}, D_instr, 32'h0);
    chk({tag, "_dvalid"}, {31'b0, D_valid}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    npc = 32'h0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Zero-wait streaming, then a request left waiting at 300C when reset hits.
    tick();
    chk("first_req_addr", imem_addr, 32'h0000_3000);
    tick();
    chk("stream_addr1", imem_addr, 32'h0000_3004);
    chk("stream_dpc0", D_PC, 32'h0000_3000);
    chk("stream_dvalid", {31'b0, D_valid}, 32'h1);
    tick();
    tick();
    chk("stream_addr3", imem_addr, 32'h0000_300C);
    wait_k = 5;
    tick();
    tick();
    chk("wait_300c_req", {31'b0, imem_req}, 32'h1);
    rst_n = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_k = 0;

    // Restart at 3000; stall in the ack cycle of 3004 for three cycles.
    tick();
    chk("restart_addr", imem_addr, 32'h0000_3000);
    tick();
    special_addr = 32'h0000_3004;
    special_data = 32'h2408_0005;
    stall = 1'b1;
    tick();
    chk("hold_req0", {31'b0, imem_req}, 32'h0);
    tick();
    chk("hold_req1", {31'b0, imem_req}, 32'h0);
    tick();
    chk("hold_req2", {31'b0, imem_req}, 32'h0);
    chk("hold_dinstr", D_instr, 32'h0000_3000 ^ 32'hFFFF_FFFF);
    stall = 1'b0;
    tick();
    chk("release_dinstr", D_instr, 32'h2408_0005);
    chk("release_dpc", D_PC, 32'h0000_3004);

    // Branch target presented while the delay slot at 3008 is fetched.
    branch_at = 32'h0000_3008;
    branch_target = 32'h0000_3040;
    tick();
    chk("delay_slot_dpc", D_PC, 32'h0000_3008);
    chk("branch_addr", imem_addr, 32'h0000_3040);
    branch_at = 32'h0000_0001;

    // Two wait cycles: two bubbles, address held for three cycles.
    wait_k = 2;
    tick();
    chk("wait_bubble1", {D_instr[30:0], D_valid}, 32'h0);
    chk("wait_addr1", imem_addr, 32'h0000_3040);
    tick();
    chk("wait_bubble2", {D_instr[30:0], D_valid}, 32'h0);
    chk("wait_addr2", imem_addr, 32'h0000_3040);
    tick();
    chk("wait_dpc", D_PC, 32'h0000_3040);
    chk("wait_next_addr", imem_addr, 32'h0000_3044);

    // Stall while the request waits; the late ack must go to HOLD.
    wait_k = 3;
    stall = 1'b1;
    repeat (5) tick();
    chk("late_ack_dpc", D_PC, 32'h0000_3040);
    chk("late_ack_req", {31'b0, imem_req}, 32'h0);
    stall = 1'b0;
    tick();
    chk("late_ack_release", D_PC, 32'h0000_3044);

    // Randomized traffic: stalls, variable wait, stray acks, random npc.
    rnd = 1'b1;
    stray = 1'b1;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
